mux4_to_1: RTL and testbench

MUX4_TO_1 -- requirements
Module: mux4_to_1

---
 rtl/mux4_to_1.sv | 62 ++++++
 tb/tb_mux4_to_1.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mux4_to_1.sv
// Registered 4:1 multiplexer with a sample-enable handshake.
// The output register also records which select code produced the held data.
module mux4_to_1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] f,
    output logic             out_valid,
    output logic [1:0]       out_sel
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] f_d, f_q;
    logic [1:0]       out_sel_d, out_sel_q;
    logic             out_valid_d, out_valid_q;

    always_comb begin
        sel_data = '0;
        unique case (sel)
            2'b00: sel_data = a;
            2'b01: sel_data = b;
            2'b10: sel_data = c;
            2'b11: sel_data = d;
        endcase
    end

    // Data and select hold when idle; only the valid flag drops.
    always_comb begin
        f_d         = f_q;
        out_sel_d   = out_sel_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            f_d         = sel_data;
            out_sel_d   = sel;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q         <= '0;
            out_sel_q   <= 2'b00;
            out_valid_q <= 1'b0;
        end else begin
            f_q         <= f_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign f         = f_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4_to_1.sv
// Scoreboard bench for mux4_to_1: WIDTH=8 and WIDTH=1 instances share stimulus;
// the 1-bit instance sees bit 0 of each data input.
module tb_mux4_to_1;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] sel = 2'b00;
    logic [7:0] a = '0, b = '0, c = '0, d = '0;

    logic [7:0] f8;
    logic       f1;
    logic [1:0] os8, os1;
    logic       ov8, ov1;

    mux4_to_1 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .sel(sel),
        .in_valid(in_valid), .f(f8), .out_valid(ov8), .out_sel(os8)
    );

    mux4_to_1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .sel(sel),
        .in_valid(in_valid), .f(f1), .out_valid(ov1), .out_sel(os1)
    );

    typedef struct packed {
        logic [7:0] f;
        logic [1:0] s;
        logic       v;
    } exp_t;

    exp_t q[$];
    exp_t m;            // reference state after the most recent edge
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: one expected record per edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("f_w8", {24'b0, f8}, {24'b0, e.f});
                check("f_w1", {31'b0, f1}, {31'b0, e.f[0]});
                check("out_sel_w8", {30'b0, os8}, {30'b0, e.s});
                check("out_sel_w1", {30'b0, os1}, {30'b0, e.s});
                check("out_valid_w8", {31'b0, ov8}, {31'b0, e.v});
                check("out_valid_w1", {31'b0, ov1}, {31'b0, e.v});
            end
        end
    end

    // Drive one cycle of stimulus and push the model's view of the following edge.
    task automatic step(input bit r, input bit iv, input logic [1:0] s,
                        input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] ic, input logic [7:0] id);
        logic [7:0] arr [4];
        @(negedge clk);
        rst = r; in_valid = iv; sel = s;
        a = ia; b = ib; c = ic; d = id;
        arr[0] = ia; arr[1] = ib; arr[2] = ic; arr[3] = id;
        if (r) begin
            m.f = '0; m.s = 2'b00; m.v = 1'b0;
        end else if (iv) begin
            m.f = arr[s]; m.s = s; m.v = 1'b1;
        end else begin
            m.v = 1'b0;
        end
        q.push_back(m);
        @(posedge clk);
    endtask

    // Shake every input (including rst) between edges; outputs must not move.
    task automatic glitch();
        #3;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
        sel = 2'($urandom); rst = 1'b1; in_valid = ~in_valid;
        #1;
        check("glitch_f", {24'b0, f8}, {24'b0, m.f});
        check("glitch_valid", {31'b0, ov8}, {31'b0, m.v});
        check("glitch_sel", {30'b0, os8}, {30'b0, m.s});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] p;
        m = '0;
        step(1, 0, 2'b00, 0, 0, 0, 0);
        step(1, 1, 2'b11, 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        // Directed one-hot selection, {a,b,c,d} as bit 0 patterns
        step(0, 1, 2'b00, 1, 0, 0, 0);
        step(0, 1, 2'b01, 1, 0, 0, 0);
        step(0, 1, 2'b01, 0, 1, 0, 0);
        step(0, 1, 2'b10, 0, 0, 1, 0);
        step(0, 1, 2'b11, 0, 0, 0, 1);

        // Exhaustive sweep
        for (int s = 0; s < 4; s++) begin
            for (int pat = 0; pat < 16; pat++) begin
                p = 4'(pat);
                step(0, 1, 2'(s), {7'b0, p[3]}, {7'b0, p[2]}, {7'b0, p[1]}, {7'b0, p[0]});
            end
        end

        // Hold
        step(0, 1, 2'b00, 1, 0, 0, 0);
        step(0, 0, 2'b00, 0, 0, 0, 0);
        step(0, 0, 2'b01, 0, 0, 0, 0);

        // Reset beats in_valid, then normal capture resumes
        step(0, 1, 2'b10, 0, 0, 1, 0);
        step(1, 1, 2'b11, 1, 1, 1, 1);
        step(0, 1, 2'b11, 0, 0, 0, 1);

        // Wide back-to-back walk
        for (int s = 0; s < 4; s++)
            step(0, 1, 2'(s), 8'hA5, 8'h3C, 8'hFF, 8'h00);

        // Between-edge changes, including a stray rst pulse
        step(0, 1, 2'b01, 8'h11, 8'h5A, 8'h33, 8'h44);
        glitch();
        step(0, 0, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00);
        glitch();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(19) == 0), 1'($urandom), 2'($urandom),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(15) == 0) glitch();
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
